// File: rtl/sram_req_fifo.sv
// rtl/sram_req_fifo.sv - in-order request buffer feeding the SRAM-subsystem state machine
//
// Ports:
//   CLK, ASYNCRESETN        clock (rising edge), asynchronous active-low reset
//   flush                   synchronous clear of all entries and the overflow flag
//   enq_valid/enq_ready     producer handshake; enq_cmd/enq_data carry the request
//   deq_valid/deq_ready     consumer handshake on the head entry
//   offer/receive           head cmd/data, IDLE_CMD/0 while empty
//   count                   occupancy 0..DEPTH
//   overflow                sticky, set when a request is offered while full

module sram_req_fifo #(
    parameter int               DEPTH    = 4,
    parameter int               DATA_W   = 16,
    parameter int               CMD_W    = 4,
    parameter logic [CMD_W-1:0] IDLE_CMD = 4'hF
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [CMD_W-1:0]         enq_cmd,
    input  logic [DATA_W-1:0]        enq_data,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [CMD_W-1:0]         offer,
    output logic [DATA_W-1:0]        receive,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CMD_W-1:0]  mem_cmd  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Flags come from the count register only, so enq_ready never depends
    // combinationally on deq_ready: a pop while full does not free the slot
    // until the following cycle.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = enq_valid & ~full;
    assign pop   = deq_ready & ~empty;

    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Head read is from registered state only; no input-to-output path.
    assign offer   = empty ? IDLE_CMD : mem_cmd[rd_ptr];
    assign receive = empty ? '0       : mem_data[rd_ptr];

    // Storage needs no reset; an unwritten slot is never visible because
    // the outputs are masked while empty.
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem_cmd[wr_ptr]  <= enq_cmd;
            mem_data[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (enq_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
